// File: rtl/instruction_decode.sv
// ID stage: decode, register file, hazard detection and early beq resolution.
// Defining REGFILE_BYPASS_EN forwards a same-cycle write-back to the register reads.
module instruction_decode (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] IF_ID_pc,
    input  logic [31:0] IF_ID_inst,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        ex_mem_reg_write,
    input  logic        ex_mem_mem_read,
    input  logic [4:0]  ex_mem_rd,
    input  logic [31:0] ex_mem_alu_result,
    output logic        pc_write,
    output logic        IF_ID_write,
    output logic        pc_src,
    output logic [31:0] pc_branch,
    output logic        IF_flush,
    output logic [31:0] ID_EX_pc,
    output logic [31:0] ID_EX_rs1_data,
    output logic [31:0] ID_EX_rs2_data,
    output logic [31:0] ID_EX_imm,
    output logic [4:0]  ID_EX_rs1,
    output logic [4:0]  ID_EX_rs2,
    output logic [4:0]  ID_EX_rd,
    output logic [3:0]  ID_EX_funct,
    output logic [6:0]  ID_EX_ctrl
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  ctrl;
    logic [31:0] imm;
    logic        use_rs1;
    logic        use_rs2;
    logic        is_beq;
    logic [31:0] regs [32];
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        load_use;
    logic        branch_hazard;
    logic        stall;
    logic [31:0] cmp1;
    logic [31:0] cmp2;
    logic        taken;

    assign opcode = IF_ID_inst[6:0];
    assign rd     = IF_ID_inst[11:7];
    assign rs1    = IF_ID_inst[19:15];
    assign rs2    = IF_ID_inst[24:20];

    // ctrl = {reg_write, mem_to_reg, mem_read, mem_write, alu_src, alu_op}
    always_comb begin
        ctrl    = '0;
        imm     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        is_beq  = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl    = 7'b1000010;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_IALU: begin
                ctrl    = 7'b1000111;
                imm     = {{20{IF_ID_inst[31]}}, IF_ID_inst[31:20]};
                use_rs1 = 1'b1;
            end
            OP_LW: begin
                ctrl    = 7'b1110100;
                imm     = {{20{IF_ID_inst[31]}}, IF_ID_inst[31:20]};
                use_rs1 = 1'b1;
            end
            OP_SW: begin
                ctrl    = 7'b0001100;
                imm     = {{20{IF_ID_inst[31]}}, IF_ID_inst[31:25], IF_ID_inst[11:7]};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_BEQ: begin
                ctrl    = 7'b0000001;
                imm     = {{19{IF_ID_inst[31]}}, IF_ID_inst[31], IF_ID_inst[7],
                           IF_ID_inst[30:25], IF_ID_inst[11:8], 1'b0};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                is_beq  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_reg_write && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rs1_data = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
        rs2_data = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
`ifdef REGFILE_BYPASS_EN
        if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs1) begin
            rs1_data = wb_data;
        end
        if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs2) begin
            rs2_data = wb_data;
        end
`else
`endif
    end

    always_comb begin
        load_use = ID_EX_ctrl[4] && (ID_EX_rd != 5'd0) &&
                   ((use_rs1 && rs1 == ID_EX_rd) || (use_rs2 && rs2 == ID_EX_rd));
        // beq resolves here, so it must wait for any result not yet forwardable from EX/MEM
        branch_hazard = is_beq &&
            ((ID_EX_ctrl[6] && ID_EX_rd != 5'd0 && (rs1 == ID_EX_rd || rs2 == ID_EX_rd)) ||
             (ex_mem_mem_read && ex_mem_rd != 5'd0 && (rs1 == ex_mem_rd || rs2 == ex_mem_rd)));
        stall = load_use || branch_hazard;
    end

    always_comb begin
        cmp1 = rs1_data;
        cmp2 = rs2_data;
        if (ex_mem_reg_write && !ex_mem_mem_read && ex_mem_rd != 5'd0 && ex_mem_rd == rs1) begin
            cmp1 = ex_mem_alu_result;
        end
        if (ex_mem_reg_write && !ex_mem_mem_read && ex_mem_rd != 5'd0 && ex_mem_rd == rs2) begin
            cmp2 = ex_mem_alu_result;
        end
        taken = is_beq && !stall && (cmp1 == cmp2);
    end

    assign pc_write    = !stall;
    assign IF_ID_write = !stall;
    assign pc_src      = taken;
    assign IF_flush    = taken;
    assign pc_branch   = IF_ID_pc + imm;

    // A stall inserts a fully cleared bubble rather than a ctrl-only bubble
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ID_EX_pc       <= '0;
            ID_EX_rs1_data <= '0;
            ID_EX_rs2_data <= '0;
            ID_EX_imm      <= '0;
            ID_EX_rs1      <= '0;
            ID_EX_rs2      <= '0;
            ID_EX_rd       <= '0;
            ID_EX_funct    <= '0;
            ID_EX_ctrl     <= '0;
        end else if (stall) begin
            ID_EX_pc       <= '0;
            ID_EX_rs1_data <= '0;
            ID_EX_rs2_data <= '0;
            ID_EX_imm      <= '0;
            ID_EX_rs1      <= '0;
            ID_EX_rs2      <= '0;
            ID_EX_rd       <= '0;
            ID_EX_funct    <= '0;
            ID_EX_ctrl     <= '0;
        end else begin
            ID_EX_pc       <= IF_ID_pc;
            ID_EX_rs1_data <= rs1_data;
            ID_EX_rs2_data <= rs2_data;
            ID_EX_imm      <= imm;
            ID_EX_rs1      <= rs1;
            ID_EX_rs2      <= rs2;
            ID_EX_rd       <= rd;
            ID_EX_funct    <= {IF_ID_inst[30], IF_ID_inst[14:12]};
            ID_EX_ctrl     <= ctrl;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: expected ID/EX contents are queued
// when an instruction is presented and compared after the capturing clock edge.
module tb_instruction_decode;

    logic        clk;
    logic        reset_n;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_mem_reg_write;
    logic        ex_mem_mem_read;
    logic [4:0]  ex_mem_rd;
    logic [31:0] ex_mem_alu_result;
    logic        pc_write;
    logic        IF_ID_write;
    logic        pc_src;
    logic [31:0] pc_branch;
    logic        IF_flush;
    logic [31:0] ID_EX_pc;
    logic [31:0] ID_EX_rs1_data;
    logic [31:0] ID_EX_rs2_data;
    logic [31:0] ID_EX_imm;
    logic [4:0]  ID_EX_rs1;
    logic [4:0]  ID_EX_rs2;
    logic [4:0]  ID_EX_rd;
    logic [3:0]  ID_EX_funct;
    logic [6:0]  ID_EX_ctrl;

    typedef logic [153:0] idex_t;

    int    total = 0;
    int    bad = 0;
    idex_t sb[$];
    idex_t got;
    idex_t exp_v;
    logic [31:0] model_rf [32];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [6:0] C_R    = 7'b1000010;
    localparam logic [6:0] C_IALU = 7'b1000111;
    localparam logic [6:0] C_LW   = 7'b1110100;
    localparam logic [6:0] C_SW   = 7'b0001100;
    localparam logic [6:0] C_BEQ  = 7'b0000001;

    instruction_decode dut (
        .clk(clk), .reset_n(reset_n),
        .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read),
        .ex_mem_rd(ex_mem_rd), .ex_mem_alu_result(ex_mem_alu_result),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write), .pc_src(pc_src),
        .pc_branch(pc_branch), .IF_flush(IF_flush),
        .ID_EX_pc(ID_EX_pc), .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
        .ID_EX_imm(ID_EX_imm), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_funct(ID_EX_funct), .ID_EX_ctrl(ID_EX_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic idex_t dut_id_ex();
        return {ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm,
                ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_funct, ID_EX_ctrl};
    endfunction

    function automatic idex_t expect_data(input logic [31:0] pc, input logic [31:0] inst,
                                          input logic [31:0] imm, input logic [6:0] ctrl,
                                          input logic [31:0] d1, input logic [31:0] d2);
        return {pc, d1, d2, imm, inst[19:15], inst[24:20], inst[11:7],
                {inst[30], inst[14:12]}, ctrl};
    endfunction

    function automatic idex_t expect_of(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic [31:0] imm, input logic [6:0] ctrl);
        return expect_data(pc, inst, imm, ctrl, model_rf[inst[19:15]], model_rf[inst[24:20]]);
    endfunction

    task automatic clock_edge();
        @(posedge clk);
        #1;
        if (wb_reg_write && wb_rd != 5'd0) model_rf[wb_rd] = wb_data;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] inst);
        @(negedge clk);
        IF_ID_pc   = pc;
        IF_ID_inst = inst;
        #1;
    endtask

    task automatic write_reg(input logic [4:0] rd, input logic [31:0] data);
        @(negedge clk);
        IF_ID_inst   = 32'd0;
        wb_reg_write = 1'b1;
        wb_rd        = rd;
        wb_data      = data;
        clock_edge();
        wb_reg_write = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (dut_id_ex() !== '0) begin
            bad++; $display("FAIL reset_id_ex: got %h want 0", dut_id_ex());
        end
        total++;
        if ({pc_write, IF_ID_write, pc_src, IF_flush} !== 4'b1100) begin
            bad++; $display("FAIL reset_ctl: got %b want 1100", {pc_write, IF_ID_write, pc_src, IF_flush});
        end
        total++;
        if (pc_branch !== 32'h100) begin
            bad++; $display("FAIL reset_pc_branch: got %h want 00000100", pc_branch);
        end
        @(negedge clk);
        reset_n = 1'b1;
        write_reg(5'd5, 32'd7);
        present(32'h8, enc_r(7'h00, 5'd0, 5'd5, 5'd6));
        sb.push_back(expect_data(32'h8, IF_ID_inst, 32'd0, C_R, 32'd7, 32'd0));
        clock_edge();
        got = dut_id_ex(); exp_v = sb.pop_front(); total++;
        if (got !== exp_v) begin
            bad++; $display("FAIL reset_pre_x5: got %h want %h", got, exp_v);
        end
        #2;
        reset_n    = 1'b0;
        IF_ID_inst = 32'd0;
        IF_ID_pc   = 32'h2C;
        #1;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        total++;
        if (dut_id_ex() !== '0) begin
            bad++; $display("FAIL reset_async_id_ex: got %h want 0", dut_id_ex());
        end
        total++;
        if ({pc_write, IF_ID_write, pc_src, IF_flush, pc_branch} !== {4'b1100, 32'h2C}) begin
            bad++; $display("FAIL reset_async_ctl: got %b %h want 1100 0000002c",
                            {pc_write, IF_ID_write, pc_src, IF_flush}, pc_branch);
        end
        @(negedge clk);
        reset_n = 1'b1;
        present(32'hC, enc_r(7'h00, 5'd0, 5'd5, 5'd6));
        sb.push_back(expect_data(32'hC, IF_ID_inst, 32'd0, C_R, 32'd0, 32'd0));
        clock_edge();
        got = dut_id_ex(); exp_v = sb.pop_front(); total++;
        if (got !== exp_v) begin
            bad++; $display("FAIL reset_x5_cleared: got %h want %h", got, exp_v);
        end
    endtask

    task automatic test_decode();
        logic [31:0] pcs [8];
        logic [31:0] insts [8];
        logic [31:0] imms [8];
        logic [6:0]  ctrls [8];
        write_reg(5'd1, 32'd5);
        write_reg(5'd2, 32'd100);
        write_reg(5'd10, 32'd3);
        pcs[0] = 32'h40; insts[0] = enc_r(7'h00, 5'd2, 5'd1, 5'd3); imms[0] = 32'd0; ctrls[0] = C_R;
        pcs[1] = 32'h44; insts[1] = enc_r(7'h20, 5'd2, 5'd1, 5'd4); imms[1] = 32'd0; ctrls[1] = C_R;
        pcs[2] = 32'h48; insts[2] = enc_i(32'hFFFFFFCE, 5'd10, 3'b000, 5'd15, 7'b0010011);
        imms[2] = 32'hFFFFFFCE; ctrls[2] = C_IALU;
        pcs[3] = 32'h4C; insts[3] = enc_i(32'd8, 5'd2, 3'b010, 5'd14, 7'b0000011);
        imms[3] = 32'd8; ctrls[3] = C_LW;
        pcs[4] = 32'h50; insts[4] = enc_s(32'hFFFFFFFC, 5'd2, 5'd1);
        imms[4] = 32'hFFFFFFFC; ctrls[4] = C_SW;
        pcs[5] = 32'h54; insts[5] = enc_b(32'd8, 5'd10, 5'd2); imms[5] = 32'd8; ctrls[5] = C_BEQ;
        pcs[6] = 32'h58; insts[6] = 32'hFFFFFFFF; imms[6] = 32'd0; ctrls[6] = 7'd0;
        pcs[7] = 32'h5C; insts[7] = enc_i(32'h7FF, 5'd1, 3'b111, 5'd9, 7'b0010011);
        imms[7] = 32'h7FF; ctrls[7] = C_IALU;
        for (int i = 0; i < 8; i++) begin
            present(pcs[i], insts[i]);
            total++;
            if ({pc_write, IF_ID_write, pc_src, IF_flush} !== 4'b1100) begin
                bad++; $display("FAIL decode_ctl[%0d]: got %b want 1100", i,
                                {pc_write, IF_ID_write, pc_src, IF_flush});
            end
            total++;
            if (pc_branch !== pcs[i] + imms[i]) begin
                bad++; $display("FAIL decode_pc_branch[%0d]: got %h want %h", i, pc_branch, pcs[i] + imms[i]);
            end
            sb.push_back(expect_of(pcs[i], insts[i], imms[i], ctrls[i]));
            clock_edge();
            got = dut_id_ex(); exp_v = sb.pop_front(); total++;
            if (got !== exp_v) begin
                bad++; $display("FAIL decode_id_ex[%0d]: got %h want %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_load_use();
        logic [31:0] inst;
        present(32'h60, enc_i(32'd0, 5'd2, 3'b010, 5'd14, 7'b0000011));
        sb.push_back(expect_of(32'h60, IF_ID_inst, 32'd0, C_LW));
        clock_edge();
        got = dut_id_ex(); exp_v = sb.pop_front(); total++;
        if (got !== exp_v) begin
            bad++; $display("FAIL lu_lw: got %h want %h", got, exp_v);
        end
        inst = enc_r(7'h00, 5'd14, 5'd19, 5'd5);
        present(32'h64, inst);
        total++;
        if ({pc_write, IF_ID_write, pc_src, IF_flush} !== 4'b0000) begin
            bad++; $display("FAIL lu_stall_ctl: got %b want 0000", {pc_write, IF_ID_write, pc_src, IF_flush});
        end
        sb.push_back('0);
        clock_edge();
        got = dut_id_ex(); exp_v = sb.pop_front(); total++;
        if (got !== exp_v) begin
            bad++; $display("FAIL lu_bubble: got %h want %h", got, exp_v);
        end
        present(32'h64, inst);
        total++;
        if ({pc_write, IF_ID_write} !== 2'b11) begin
            bad++; $display("FAIL lu_release: got %b want 11", {pc_write, IF_ID_write});
        end
        sb.push_back(expect_of(32'h64, inst, 32'd0, C_R));
        clock_edge();
        got = dut_id_ex(); exp_v = sb.pop_front(); total++;
        if (got !== exp_v) begin
            bad++; $display("FAIL lu_add_issue: got %h want %h", got, exp_v);
        end
        present(32'h68, enc_i(32'd0, 5'd2, 3'b010, 5'd0, 7'b0000011));
        clock_edge();
        present(32'h6C, enc_r(7'h00, 5'd0, 5'd0, 5'd5));
        total++;
        if (pc_write !== 1'b1) begin
            bad++; $display("FAIL lu_rd0_no_stall: got %b want 1", pc_write);
        end
        clock_edge();
    endtask

    task automatic test_branch();
        write_reg(5'd1, 32'd3);
        write_reg(5'd10, 32'd3);
        present(32'h1C, enc_b(32'd12, 5'd10, 5'd1));
        total++;
        if ({pc_write, pc_src, IF_flush, pc_branch} !== {3'b111, 32'h28}) begin
            bad++; $display("FAIL br_taken: got %b %h want 111 00000028",
                            {pc_write, pc_src, IF_flush}, pc_branch);
        end
        sb.push_back(expect_of(32'h1C, IF_ID_inst, 32'd12, C_BEQ));
        clock_edge();
        got = dut_id_ex(); exp_v = sb.pop_front(); total++;
        if (got !== exp_v) begin
            bad++; $display("FAIL br_id_ex: got %h want %h", got, exp_v);
        end
        present(32'hFFFFFFFC, enc_b(32'd8, 5'd0, 5'd0));
        total++;
        if ({pc_src, pc_branch} !== {1'b1, 32'h4}) begin
            bad++; $display("FAIL br_wrap: got %b %h want 1 00000004", pc_src, pc_branch);
        end
        clock_edge();
        present(32'h100, enc_b(32'hFFFFFFF0, 5'd10, 5'd1));
        total++;
        if ({pc_src, pc_branch} !== {1'b1, 32'hF0}) begin
            bad++; $display("FAIL br_neg: got %b %h want 1 000000f0", pc_src, pc_branch);
        end
        sb.push_back(expect_of(32'h100, IF_ID_inst, 32'hFFFFFFF0, C_BEQ));
        clock_edge();
        got = dut_id_ex(); exp_v = sb.pop_front(); total++;
        if (got !== exp_v) begin
            bad++; $display("FAIL br_neg_id_ex: got %h want %h", got, exp_v);
        end
    endtask

    task automatic test_forward();
        write_reg(5'd1, 32'd5);
        @(negedge clk);
        ex_mem_reg_write = 1'b1; ex_mem_mem_read = 1'b0;
        ex_mem_rd = 5'd14; ex_mem_alu_result = 32'd5;
        IF_ID_pc = 32'h200; IF_ID_inst = enc_b(32'd12, 5'd14, 5'd1);
        #1;
        total++;
        if ({pc_write, pc_src, IF_flush} !== 3'b111) begin
            bad++; $display("FAIL fw_taken: got %b want 111", {pc_write, pc_src, IF_flush});
        end
        ex_mem_mem_read = 1'b1;
        #1;
        total++;
        if ({pc_write, IF_ID_write, pc_src, IF_flush} !== 4'b0000) begin
            bad++; $display("FAIL fw_load_stall: got %b want 0000", {pc_write, IF_ID_write, pc_src, IF_flush});
        end
        sb.push_back('0);
        clock_edge();
        got = dut_id_ex(); exp_v = sb.pop_front(); total++;
        if (got !== exp_v) begin
            bad++; $display("FAIL fw_bubble: got %h want %h", got, exp_v);
        end
        @(negedge clk);
        ex_mem_mem_read = 1'b0; ex_mem_rd = 5'd0;
        IF_ID_inst = enc_b(32'd12, 5'd0, 5'd1);
        #1;
        total++;
        if ({pc_write, pc_src} !== 2'b10) begin
            bad++; $display("FAIL fw_rd0: got %b want 10", {pc_write, pc_src});
        end
        ex_mem_reg_write = 1'b0;
        clock_edge();
        present(32'h210, enc_r(7'h00, 5'd1, 5'd1, 5'd7));
        clock_edge();
        present(32'h214, enc_b(32'd8, 5'd0, 5'd7));
        total++;
        if ({pc_write, pc_src} !== 2'b00) begin
            bad++; $display("FAIL fw_idex_stall: got %b want 00", {pc_write, pc_src});
        end
        sb.push_back('0);
        clock_edge();
        got = dut_id_ex(); exp_v = sb.pop_front(); total++;
        if (got !== exp_v) begin
            bad++; $display("FAIL fw_idex_bubble: got %h want %h", got, exp_v);
        end
        present(32'h214, enc_b(32'd8, 5'd0, 5'd7));
        total++;
        if ({pc_write, pc_src} !== 2'b11) begin
            bad++; $display("FAIL fw_after_stall: got %b want 11", {pc_write, pc_src});
        end
        clock_edge();
    endtask

    task automatic test_bypass();
        write_reg(5'd12, 32'd4);
        @(negedge clk);
        IF_ID_pc = 32'h300; IF_ID_inst = enc_r(7'h00, 5'd0, 5'd12, 5'd13);
        wb_reg_write = 1'b1; wb_rd = 5'd12; wb_data = 32'd9;
        sb.push_back(expect_data(32'h300, IF_ID_inst, 32'd0, C_R, BYP ? 32'd9 : 32'd4, 32'd0));
        clock_edge();
        wb_reg_write = 1'b0;
        got = dut_id_ex(); exp_v = sb.pop_front(); total++;
        if (got !== exp_v) begin
            bad++; $display("FAIL byp_same_cycle: got %h want %h", got, exp_v);
        end
        present(32'h304, enc_r(7'h00, 5'd0, 5'd12, 5'd13));
        sb.push_back(expect_of(32'h304, IF_ID_inst, 32'd0, C_R));
        clock_edge();
        got = dut_id_ex(); exp_v = sb.pop_front(); total++;
        if (got !== exp_v) begin
            bad++; $display("FAIL byp_next_cycle: got %h want %h", got, exp_v);
        end
        @(negedge clk);
        IF_ID_pc = 32'h310; IF_ID_inst = enc_b(32'd8, 5'd1, 5'd12);
        wb_reg_write = 1'b1; wb_rd = 5'd12; wb_data = 32'd5;
        #1;
        total++;
        if (pc_src !== BYP) begin
            bad++; $display("FAIL byp_branch: got %b want %b", pc_src, BYP);
        end
        clock_edge();
        wb_reg_write = 1'b0;
        @(negedge clk);
        IF_ID_pc = 32'h320; IF_ID_inst = enc_r(7'h00, 5'd0, 5'd0, 5'd13);
        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
        sb.push_back(expect_data(32'h320, IF_ID_inst, 32'd0, C_R, 32'd0, 32'd0));
        clock_edge();
        wb_reg_write = 1'b0;
        got = dut_id_ex(); exp_v = sb.pop_front(); total++;
        if (got !== exp_v) begin
            bad++; $display("FAIL byp_x0: got %h want %h", got, exp_v);
        end
        present(32'h324, enc_r(7'h00, 5'd0, 5'd0, 5'd13));
        sb.push_back(expect_data(32'h324, IF_ID_inst, 32'd0, C_R, 32'd0, 32'd0));
        clock_edge();
        got = dut_id_ex(); exp_v = sb.pop_front(); total++;
        if (got !== exp_v) begin
            bad++; $display("FAIL byp_x0_stays: got %h want %h", got, exp_v);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        IF_ID_pc = 32'h100; IF_ID_inst = 32'd0;
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        ex_mem_reg_write = 1'b0; ex_mem_mem_read = 1'b0;
        ex_mem_rd = 5'd0; ex_mem_alu_result = 32'd0;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        #2;
        test_reset();
        test_decode();
        test_load_use();
        test_branch();
        test_forward();
        test_bypass();
        total++;
        if (sb.size() !== 0) begin
            bad++; $display("FAIL sb_drain: got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
